cnt_seq_checker: RTL and testbench

Receive-side monitor for the free-running WIDTH-bit up-counter stream produced by the counter block. It samples the counter value on qualified cycles, locks onto the +1 sequence, then flags, counts and captures every sequence break. It sits beside the counter in test and debug builds, and its status outputs feed the debug register file.

---
 rtl/cnt_seq_checker.sv | 188 ++++++++++++++++++
 tb/tb_cnt_seq_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_checker.sv
// Sequence checker for a free-running WIDTH-bit up-counter stream: locks onto +1 steps and
// flags, counts and captures breaks. Optional stall detection under CNT_SEQ_CHECKER_STALL_EN.
module cnt_seq_checker #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned WRAP_CNT_W = 8,
    parameter int unsigned LOCK_CNT   = 2,
    parameter int unsigned STALL_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  cnt_vld,
    input  logic [WIDTH-1:0]      cnt_in,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]      last_bad,
    output logic                  stall,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        StUnsync = 2'd0,
        StSync   = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        exp_q, exp_d;
    logic [WIDTH-1:0]        last_bad_q, last_bad_d;
    logic [3:0]              good_run_q, good_run_d;
    logic                    locked_q, locked_d;
    logic                    err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [WRAP_CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0]        cnt_inc;
    logic [3:0]              good_run_inc;
    logic                    match;
    logic                    stall_hit;

    assign cnt_inc      = cnt_in + WIDTH'(1);
    assign good_run_inc = good_run_q + 4'd1;
    assign match        = (cnt_in == exp_q);

`ifdef CNT_SEQ_CHECKER_STALL_EN
    localparam int unsigned IdleW = $clog2(STALL_CYC + 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             stall_q, stall_d;

    // Fires on the idle cycle that brings the count up to STALL_CYC.
    assign stall_hit = (state_q == StLocked) && !cnt_vld &&
                       ((idle_q + IdleW'(1)) == IdleW'(STALL_CYC));

    always_comb begin
        idle_d  = '0;
        stall_d = stall_q;
        if (clr) begin
            stall_d = 1'b0;
        end else begin
            if (stall_hit) begin
                stall_d = 1'b1;
            end else if (state_q == StLocked && !cnt_vld) begin
                idle_d = idle_q + IdleW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            idle_q  <= idle_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall_hit = 1'b0;
    assign stall     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        last_bad_d  = last_bad_q;
        good_run_d  = good_run_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        wrap_cnt_d  = wrap_cnt_q;

        if (clr) begin
            state_d    = StUnsync;
            last_bad_d = '0;
            good_run_d = '0;
            locked_d   = 1'b0;
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            case (state_q)
                StUnsync: begin
                    if (cnt_vld) begin
                        exp_d      = cnt_inc;
                        good_run_d = '0;
                        state_d    = StSync;
                    end
                end
                StSync: begin
                    if (cnt_vld) begin
                        exp_d = cnt_inc;
                        if (match) begin
                            good_run_d = good_run_inc;
                            if (good_run_inc == 4'(LOCK_CNT)) begin
                                state_d  = StLocked;
                                locked_d = 1'b1;
                            end
                        end else begin
                            good_run_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if (cnt_vld) begin
                        exp_d = cnt_inc;
                        if (match) begin
                            if (cnt_in == '0) begin
                                wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
                            end
                        end else begin
                            err_pulse_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                            end
                            last_bad_d = cnt_in;
                            good_run_d = '0;
                            state_d    = StSync;
                            locked_d   = 1'b0;
                        end
                    end else if (stall_hit) begin
                        state_d  = StUnsync;
                        locked_d = 1'b0;
                    end
                end
                // Unused encoding recovers to UNSYNC.
                default: begin
                    state_d  = StUnsync;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StUnsync;
            exp_q       <= '0;
            last_bad_q  <= '0;
            good_run_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            last_bad_q  <= last_bad_d;
            good_run_q  <= good_run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign last_bad  = last_bad_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: vector table for lock/wrap/break/clear, plus hand-written
// saturation, stall and asynchronous-reset sequences.
module tb_cnt_seq_checker;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clr = 1'b0;
    logic       cnt_vld = 1'b0;
    logic [2:0] cnt_in = '0;
    logic       locked;
    logic       err_pulse;
    logic [1:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [2:0] last_bad;
    logic       stall;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cnt_seq_checker #(
        .WIDTH     (3),
        .ERR_CNT_W (2),
        .WRAP_CNT_W(8),
        .LOCK_CNT  (2),
        .STALL_CYC (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .cnt_vld  (cnt_vld),
        .cnt_in   (cnt_in),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .wrap_cnt (wrap_cnt),
        .last_bad (last_bad),
        .stall    (stall),
        .state    (state)
    );

    typedef struct {
        logic       c;
        logic       v;
        logic [2:0] d;
        logic [1:0] st;
        logic       lk;
        logic       ep;
        logic [1:0] ec;
        logic [7:0] wc;
        logic [2:0] lb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [2:0] d);
        @(negedge clk);
        clr     = c;
        cnt_vld = v;
        cnt_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic c, input logic v, input logic [2:0] d, input logic [1:0] st,
                       input logic lk, input logic ep, input logic [1:0] ec, input logic [7:0] wc,
                       input logic [2:0] lb);
        vec_t x;
        x.c = c; x.v = v; x.d = d; x.st = st; x.lk = lk; x.ep = ep;
        x.ec = ec; x.wc = wc; x.lb = lb;
        vecs.push_back(x);
    endtask

    initial begin
        //   clr vld  in  st lk ep ec wc lb
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);  // UNSYNC -> SYNC
        add(0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 2, 2, 1, 0, 0, 0, 0);  // locked
        add(0, 1, 3, 2, 1, 0, 0, 0, 0);
        add(0, 1, 4, 2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 2, 1, 0, 0, 0, 0);  // gap, not an error
        add(0, 1, 5, 2, 1, 0, 0, 0, 0);
        add(0, 1, 6, 2, 1, 0, 0, 0, 0);
        add(0, 1, 7, 2, 1, 0, 0, 0, 0);
        add(0, 1, 0, 2, 1, 0, 0, 1, 0);  // legal wrap
        add(0, 1, 1, 2, 1, 0, 0, 1, 0);
        add(0, 1, 2, 2, 1, 0, 0, 1, 0);
        add(0, 1, 3, 2, 1, 0, 0, 1, 0);
        add(0, 1, 4, 2, 1, 0, 0, 1, 0);
        add(0, 1, 6, 1, 0, 1, 1, 1, 6);  // break
        add(0, 1, 7, 1, 0, 0, 1, 1, 6);  // pulse is one cycle
        add(0, 1, 0, 2, 1, 0, 1, 1, 6);  // relock; wrap in SYNC not counted
        add(0, 1, 0, 1, 0, 1, 2, 1, 0);  // repeated value is a break
        add(0, 1, 5, 1, 0, 0, 2, 1, 0);  // second mismatch, no new error
        add(0, 1, 6, 1, 0, 0, 2, 1, 0);
        add(0, 1, 7, 2, 1, 0, 2, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);  // clr beats a would-be wrap
        add(0, 1, 5, 1, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_wrap_cnt", 32'(wrap_cnt), 0);
        check("rst_last_bad", 32'(last_bad), 0);
        check("rst_stall", 32'(stall), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].v, vecs[i].d);
            check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].lk));
            check($sformatf("v%0d_err_pulse", i), 32'(err_pulse), 32'(vecs[i].ep));
            check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].ec));
            check($sformatf("v%0d_wrap_cnt", i), 32'(wrap_cnt), 32'(vecs[i].wc));
            check($sformatf("v%0d_last_bad", i), 32'(last_bad), 32'(vecs[i].lb));
            check($sformatf("v%0d_stall", i), 32'(stall), 0);
        end

        // Saturation: relock via 1,2,3 then break with 5 (expected 4), five times.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1);
            step(0, 1, 2);
            step(0, 1, 3);
            check($sformatf("sat%0d_locked", i), 32'(locked), 1);
            step(0, 1, 5);
            check($sformatf("sat%0d_err_pulse", i), 32'(err_pulse), 1);
            check($sformatf("sat%0d_err_cnt", i), 32'(err_cnt), (i < 3) ? i + 1 : 3);
            check($sformatf("sat%0d_last_bad", i), 32'(last_bad), 5);
            check($sformatf("sat%0d_state", i), 32'(state), 1);
        end

        // Stall: relock, then idle cycles.
        step(0, 1, 1);
        step(0, 1, 2);
        step(0, 1, 3);
        check("stall_pre_locked", 32'(locked), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("stall_idle3_state", 32'(state), 2);
        check("stall_idle3_stall", 32'(stall), 0);
        step(0, 0, 0);
`ifdef CNT_SEQ_CHECKER_STALL_EN
        check("stall_flag", 32'(stall), 1);
        check("stall_state", 32'(state), 0);
        check("stall_locked", 32'(locked), 0);
`else
        check("stall_flag", 32'(stall), 0);
        check("stall_state", 32'(state), 2);
        check("stall_locked", 32'(locked), 1);
`endif
        check("stall_err_cnt", 32'(err_cnt), 3);
        check("stall_err_pulse", 32'(err_pulse), 0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_err_cnt", 32'(err_cnt), 0);
        check("arst_last_bad", 32'(last_bad), 0);
        check("arst_stall", 32'(stall), 0);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 1, 4);
        check("post_rst_state", 32'(state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
